pararam_spi_bridge: RTL and testbench
=====================================

Name: pararam_spi_bridge

Overview:
- SPI-slave (mode 0) front end that drives the single-port ParaRAM macro's en/wc/addr/data pins and reads its registered data_out.
- Sits directly upstream of the RAM: converts serial command frames into one-cycle RAM read/write strobes, with optional address auto-increment bursts.
- Single clock domain; SPI pins are asynchronous and are synchronised into clk.

Parameters:
- ADDR_WIDTH, 9, RAM address width (must be <= 14).
- DATA_WIDTH, 16, RAM word width; also the SPI data word length.
- HDR_BITS, 16, command header length in SPI bits.

Ports:
- clk  input  1  system clock, also the RAM clock.
- rst  input  1  asynchronous active-high reset.
- spi_sck  input  1  SPI clock, asynchronous; frequency <= clk/16.
- spi_csn  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  serial data in, MSB first.
- spi_miso  output  1  serial data out, MSB first.
- spi_miso_oe  output  1  1 = drive spi_miso; high only in read states while csn is low.
- ram_en  output  1  RAM enable strobe, one clk wide.
- ram_wc  output  1  1 = write, 0 = read; valid only with ram_en, low otherwise.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM data_out; valid the cycle after a read strobe is sampled.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - Outputs: all outputs 0; ram_addr and ram_wdata 0.
  - Internals: FSM to IDLE; shift registers and bit counter cleared.
  - Synchroniser flops reset to idle levels: csn=1, sck=0.
- Synchronisation and edge detection:
  - sck, csn and mosi each pass through a 2-flop synchroniser.
  - Edge detect on the synchronised sck gives sck_rise and sck_fall; mosi is sampled on sck_rise.
- Frame format (csn low):
  - HDR_BITS header: bit15 = wr, bit14 = burst, bits[ADDR_WIDTH-1:0] = start address; other bits ignored.
  - The header is followed by DATA_WIDTH-bit data words.
- FSM states: IDLE, HDR, WR_DATA, RD_FETCH, RD_WAIT, RD_SHIFT, DONE.
  - IDLE -> HDR on synchronised csn falling.
  - HDR: shift 16 bits in. On the 16th sck_rise, latch the address and flags, then go to WR_DATA if wr=1, else to RD_FETCH.
  - WR_DATA: shift DATA_WIDTH bits in. On the last sck_rise, in the next clk assert ram_en=1, ram_wc=1 with ram_wdata = word for exactly 1 cycle.
    - Then if burst: ram_addr+1 and stay in WR_DATA.
    - Else: go to DONE.
  - RD_FETCH: ram_en=1, ram_wc=0 for 1 cycle -> RD_WAIT.
  - RD_WAIT: 1 cycle, RAM registers data_out. Next cycle: capture ram_rdata into the tx shift register -> RD_SHIFT.
  - RD_SHIFT:
    - spi_miso is updated on each sck_fall (first fall after header/word end presents the MSB).
    - The bit counter advances on sck_rise.
    - After DATA_WIDTH rises: if burst, ram_addr+1 -> RD_FETCH; else -> DONE.
  - DONE: ignores sck; spi_miso=0. Exits to IDLE only on csn high.
- Read latency: header/word last sck_rise (detected about 3 clk after the pin edge) -> capture 3 clk later. This is comfortably before the next sck_fall given sck <= clk/16.
- Address wrap: burst increment is modulo 2^ADDR_WIDTH (511 -> 0 at default).
- csn deassert at any point:
  - FSM goes to IDLE on the next clk.
  - A partial word is discarded with no RAM strobe. A write strobe already issued completes.
  - spi_miso_oe drops on the same clk.
- A csn deassert that coincides with a word's final sck_rise still counts the word as complete: the strobe is issued, then IDLE.
- ram_wc is never 1 outside the write strobe, so the RAM's data-pin direction stays read-side.
- sck edges while csn is high are ignored. A new csn low restarts a fresh header.

Decomposition:
- pararam_pkg:
  - FSM state enum.
  - Constants: HDR_BITS=16, HDR_WR_BIT=15, HDR_BURST_BIT=14.
  - Shared ADDR_WIDTH/DATA_WIDTH defaults, also used by the RAM wrapper and the bench.
- One sub-module: pararam_sync_edge.
  - 2-flop synchroniser plus rise/fall detect, with a parameterised reset value.
  - Instantiated for sck (reset 0), csn (reset 1) and mosi (no edge outputs used).

Test Plan:
- Single write: header 0x8005, word 0xBEEF, csn high -> exactly one ram_en=1/ram_wc=1 pulse with addr=5, wdata=0xBEEF; busy falls after csn high.
- Single read: RAM model holds 0x1234 at addr 5; header 0x0005 then 16 sck -> one read strobe at addr 5; MISO stream = 0x1234; spi_miso_oe high only during the data phase.
- Burst write with wrap: header 0xC1FF, words 0x0001, 0x0002 -> writes addr 511=0x0001, then addr 0=0x0002.
- Burst read: header 0x4010, 3 words, RAM holds 0xA0A0, 0xB1B1, 0xC2C2 at 0x10–0x12 -> MISO returns those in order; read strobes at 0x10, 0x11, 0x12.
- Abort: header 0x8003 plus 9 data bits, then csn high -> no ram_en; FSM IDLE within 4 clk. The next frame (write 0x0042 to addr 3) works normally.
- Reset mid-burst: assert rst during RD_SHIFT -> all outputs 0 immediately; after release with csn high, busy=0 and no strobe occurs.

Source files
------------

// File: rtl/pararam_pkg.sv
// Shared types and constants for the ParaRAM SPI bridge.
// Defaults here are also used by the RAM wrapper and the bench.
package pararam_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int HDR_BITS = 16;
  localparam int HDR_WR_BIT = 15;
  localparam int HDR_BURST_BIT = 14;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WR_DATA,
    RD_FETCH,
    RD_WAIT,
    RD_SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/pararam_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus
// rise/fall detect on the synchronised level.
module pararam_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/pararam_spi_bridge.sv
// SPI mode-0 slave that turns command frames into single-cycle
// ParaRAM read/write strobes, with optional auto-increment bursts.
module pararam_spi_bridge #(
  parameter int ADDR_WIDTH = pararam_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = pararam_pkg::DEF_DATA_WIDTH,
  parameter int HDR_BITS   = pararam_pkg::HDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  ram_en,
  output logic                  ram_wc,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  import pararam_pkg::*;

  localparam int SW = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);

  state_t state, state_nxt;

  logic sck_rise, sck_fall;
  logic csn_q, csn_fall;
  logic mosi_q;
  logic [3:0] edge_unused;

  logic [SW-1:0]         rx;
  logic [SW-1:0]         rx_next;
  logic [DATA_WIDTH-1:0] tx;
  logic [CW-1:0]         cnt;
  logic                  burst;
  logic                  miso_q;

  logic hdr_last, word_last, cnt_wrap;
  logic wr_strobe, rd_strobe, load_tx;
  logic shifting, rx_phase;

  pararam_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk (clk),
    .rst (rst),
    .d   (spi_sck),
    .q   (edge_unused[0]),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  pararam_sync_edge #(.RST_VAL(1'b1)) u_csn (
    .clk (clk),
    .rst (rst),
    .d   (spi_csn),
    .q   (csn_q),
    .rise(edge_unused[1]),
    .fall(csn_fall)
  );

  pararam_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk (clk),
    .rst (rst),
    .d   (spi_mosi),
    .q   (mosi_q),
    .rise(edge_unused[2]),
    .fall(edge_unused[3])
  );

  assign rx_next   = {rx[SW-2:0], mosi_q};
  assign hdr_last  = sck_rise && (cnt == CW'(HDR_BITS - 1));
  assign word_last = sck_rise && (cnt == CW'(DATA_WIDTH - 1));
  assign rx_phase  = (state == HDR) || (state == WR_DATA);
  assign shifting  = rx_phase || (state == RD_SHIFT);
  assign cnt_wrap  = (state == HDR) ? hdr_last : word_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    load_tx   = 1'b0;
    unique case (state)
      IDLE:
        if (csn_fall) state_nxt = HDR;
      HDR:
        if (hdr_last) begin
          if (rx_next[HDR_WR_BIT]) begin
            state_nxt = WR_DATA;
          end else begin
            state_nxt = RD_FETCH;
            rd_strobe = !csn_q;
          end
        end
      WR_DATA:
        // a word whose last rise lands with csn high is still written
        if (word_last) begin
          wr_strobe = 1'b1;
          if (!burst) state_nxt = DONE;
        end
      RD_FETCH:
        state_nxt = RD_WAIT;
      RD_WAIT: begin
        state_nxt = RD_SHIFT;
        load_tx   = 1'b1;
      end
      RD_SHIFT:
        if (word_last) begin
          if (burst) begin
            state_nxt = RD_FETCH;
            rd_strobe = !csn_q;
          end else begin
            state_nxt = DONE;
          end
        end
      DONE: ;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && csn_q) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_wc    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      burst     <= 1'b0;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      miso_q    <= 1'b0;
    end else begin
      ram_en <= wr_strobe | rd_strobe;
      ram_wc <= wr_strobe;
      // burst address moves on once the strobe at the old address is out
      if (state == HDR && hdr_last) begin
        ram_addr <= rx_next[ADDR_WIDTH-1:0];
        burst    <= rx_next[HDR_BURST_BIT];
      end else if (ram_en && burst) begin
        ram_addr <= ram_addr + 1'b1;
      end
      if (wr_strobe) ram_wdata <= rx_next[DATA_WIDTH-1:0];

      if (state == IDLE)
        cnt <= '0;
      else if (shifting && sck_rise)
        cnt <= cnt_wrap ? '0 : cnt + 1'b1;

      if (state == IDLE)
        rx <= '0;
      else if (rx_phase && sck_rise)
        rx <= rx_next;

      if (load_tx)
        tx <= ram_rdata;
      else if (state == RD_SHIFT && sck_fall)
        tx <= {tx[DATA_WIDTH-2:0], 1'b0};

      if (state != RD_SHIFT)
        miso_q <= 1'b0;
      else if (sck_fall)
        miso_q <= tx[DATA_WIDTH-1];
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = !csn_q &&
                       ((state == RD_FETCH) ||
                        (state == RD_WAIT)  ||
                        (state == RD_SHIFT));
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_pararam_spi_bridge.sv
// Directed bench for pararam_spi_bridge with a behavioural ParaRAM
// and a strobe monitor; SPI master runs sck at clk/20.
module tb_pararam_spi_bridge;

  import pararam_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b0;
  logic          csn = 1'b1;
  logic          mosi = 1'b0;
  logic          spi_miso, spi_miso_oe;
  logic          ram_en, ram_wc, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int checks = 0;
  int failures = 0;
  int q_addr[$];
  int q_data[$];
  int q_wc[$];
  int wc_viol = 0;
  logic [15:0] rx;

  always #5 clk = ~clk;

  pararam_spi_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (sck),
    .spi_csn    (csn),
    .spi_mosi   (mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .ram_en     (ram_en),
    .ram_wc     (ram_wc),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_wc) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_en) begin
      q_addr.push_back(int'(ram_addr));
      q_data.push_back(int'(ram_wdata));
      q_wc.push_back(int'(ram_wc));
    end
    if (ram_wc && !ram_en) wc_viol++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_wc.delete();
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clk);
    pl_addr = AW'(a);
    pl_data = DW'(d);
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic spi_bits(input logic [15:0] tx, input int n,
                          output logic [15:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[15-i];
      #100;
      sck = 1'b1;
      r = {r[14:0], spi_miso};
      #100;
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    csn = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #100;
    csn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_flags", {ram_en, ram_wc, spi_miso, spi_miso_oe, busy}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);

    // single write
    clear_q();
    frame_start();
    spi_bits(16'h8005, 16, rx);
    spi_bits(16'hBEEF, 16, rx);
    check("wr_busy", busy, 1);
    frame_end();
    check("wr_cnt", q_addr.size(), 1);
    check("wr_addr", q_addr[0], 5);
    check("wr_data", q_data[0], 16'hBEEF);
    check("wr_wc", q_wc[0], 1);
    check("wr_idle", busy, 0);

    // single read
    preload(5, 16'h1234);
    clear_q();
    frame_start();
    check("rd_oe_hdr", spi_miso_oe, 0);
    spi_bits(16'h0005, 16, rx);
    check("rd_oe_data", spi_miso_oe, 1);
    spi_bits(16'h0000, 16, rx);
    check("rd_miso", rx, 16'h1234);
    check("rd_oe_done", spi_miso_oe, 0);
    frame_end();
    check("rd_cnt", q_addr.size(), 1);
    check("rd_addr", q_addr[0], 5);
    check("rd_wc", q_wc[0], 0);
    check("rd_idle", {busy, spi_miso_oe}, 0);

    // burst write wrapping 511 -> 0
    clear_q();
    frame_start();
    spi_bits(16'hC1FF, 16, rx);
    spi_bits(16'h0001, 16, rx);
    spi_bits(16'h0002, 16, rx);
    frame_end();
    check("bwr_cnt", q_addr.size(), 2);
    check("bwr_addr0", q_addr[0], 511);
    check("bwr_data0", q_data[0], 1);
    check("bwr_addr1", q_addr[1], 0);
    check("bwr_data1", q_data[1], 2);
    check("bwr_wc", q_wc[0] + q_wc[1], 2);

    // burst read
    preload(16'h10, 16'hA0A0);
    preload(16'h11, 16'hB1B1);
    preload(16'h12, 16'hC2C2);
    clear_q();
    frame_start();
    spi_bits(16'h4010, 16, rx);
    spi_bits(16'h0000, 16, rx);
    check("brd_w0", rx, 16'hA0A0);
    spi_bits(16'h0000, 16, rx);
    check("brd_w1", rx, 16'hB1B1);
    spi_bits(16'h0000, 16, rx);
    check("brd_w2", rx, 16'hC2C2);
    frame_end();
    check("brd_cnt", q_addr.size() >= 3, 1);
    check("brd_a0", q_addr[0], 16'h10);
    check("brd_a1", q_addr[1], 16'h11);
    check("brd_a2", q_addr[2], 16'h12);
    check("brd_wc", q_wc[0] + q_wc[1] + q_wc[2], 0);

    // abort after 9 data bits
    clear_q();
    frame_start();
    spi_bits(16'h8003, 16, rx);
    spi_bits(16'hA5A5, 9, rx);
    csn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abt_busy", busy, 0);
    check("abt_cnt", q_addr.size(), 0);
    repeat (4) @(negedge clk);
    clear_q();
    frame_start();
    spi_bits(16'h8003, 16, rx);
    spi_bits(16'h0042, 16, rx);
    frame_end();
    check("abt_next_cnt", q_addr.size(), 1);
    check("abt_next_addr", q_addr[0], 3);
    check("abt_next_data", q_data[0], 16'h0042);

    // reset in the middle of a burst read
    clear_q();
    frame_start();
    spi_bits(16'h4010, 16, rx);
    spi_bits(16'h0000, 8, rx);
    check("mrst_shift", {busy, spi_miso_oe}, 2'b11);
    rst = 1'b1;
    #1;
    check("mrst_flags",
          {ram_en, ram_wc, spi_miso, spi_miso_oe, busy}, 0);
    check("mrst_addr", ram_addr, 0);
    check("mrst_wdata", ram_wdata, 0);
    clear_q();
    csn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_cnt", q_addr.size(), 0);

    check("wc_only_with_en", wc_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
